// File: rtl/led_pkg.sv
// Shared definitions for the LED front-end blocks: phase state encoding and
// millisecond-to-cycle conversion used by the blink encoder and the debouncer.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } led_state_t;

    function automatic int ms_to_cyc(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             real_clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Load wins over counting; the count parks at zero until the next load.
    always_ff @(posedge real_clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/led_blink_encoder.sv
// Replays a latched count as a train of LED blinks followed by a trailing gap,
// then pulses done. One shared phase timer is reloaded on every phase entry.
module led_blink_encoder
    import led_pkg::*;
#(
    parameter int CLK_HZ = 12_000_000,
    parameter int ON_MS  = 200,
    parameter int OFF_MS = 200,
    parameter int GAP_MS = 1000,
    parameter int WIDTH  = 4
) (
    input  logic             real_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             blink_out,
    output logic [WIDTH-1:0] remaining
);

    localparam int ON_CYC  = ms_to_cyc(CLK_HZ, ON_MS);
    localparam int OFF_CYC = ms_to_cyc(CLK_HZ, OFF_MS);
    localparam int GAP_CYC = ms_to_cyc(CLK_HZ, GAP_MS);
    localparam int MAX_CYC = max3(ON_CYC, OFF_CYC, GAP_CYC);
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYC - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYC - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYC - 1);

    if (ON_CYC < 1 || OFF_CYC < 1 || GAP_CYC < 1) begin : g_bad_timing
        $error("led_blink_encoder: every phase must last at least one cycle");
    end

    led_state_t    state;
    logic          timer_load;
    logic [TW-1:0] timer_value;
    logic          timer_expired;

    phase_timer #(
        .WIDTH(TW)
    ) u_timer (
        .real_clk(real_clk),
        .rst     (rst),
        .load    (timer_load),
        .value   (timer_value),
        .expired (timer_expired)
    );

    // The timer is reloaded on exactly the edges where the FSM changes phase.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    timer_load  = 1'b1;
                    timer_value = (value != '0) ? ON_LOAD : GAP_LOAD;
                end
            end
            ON: begin
                if (timer_expired) begin
                    timer_load  = 1'b1;
                    timer_value = (remaining > WIDTH'(1)) ? OFF_LOAD : GAP_LOAD;
                end
            end
            OFF: begin
                if (timer_expired) begin
                    timer_load  = 1'b1;
                    timer_value = ON_LOAD;
                end
            end
            default: begin
                timer_load  = 1'b0;
                timer_value = '0;
            end
        endcase
    end

    always_ff @(posedge real_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            blink_out <= 1'b0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (value != '0) begin
                            state     <= ON;
                            remaining <= value;
                            blink_out <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                ON: begin
                    if (timer_expired) begin
                        blink_out <= 1'b0;
                        if (remaining != '0) begin
                            remaining <= remaining - WIDTH'(1);
                        end
                        state <= (remaining > WIDTH'(1)) ? OFF : GAP;
                    end
                end
                OFF: begin
                    if (timer_expired) begin
                        state     <= ON;
                        blink_out <= 1'b1;
                    end
                end
                GAP: begin
                    if (timer_expired) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
